// File: rtl/core_run_ctrl.sv
// Benchmark run sequencer: holds the core in reset while the host preloads
// data memory, releases it, and counts RUN cycles until done or timeout.
module core_run_ctrl #(
  parameter int CW         = 16,
  parameter int MAX_CYCLES = 4000,
  parameter int RST_CYCLES = 2,
  parameter int AW         = 8,
  parameter int DW         = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic          core_reset,
  input  logic          core_done,
  input  logic          core_mem_we,
  input  logic [AW-1:0] core_mem_addr,
  input  logic [DW-1:0] core_mem_wdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          busy,
  output logic          finished,
  output logic          timed_out,
  output logic [CW-1:0] cycle_count
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HOLD    = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_TIMEOUT = 3'd4;

  localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_CYCLES);

  logic [2:0]    r_state;
  logic [HW-1:0] r_hold_cnt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_host_ok;
  logic          w_run;

  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
      r_cnt      <= '0;
    end else if (abort) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_TIMEOUT: begin
          if (start) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= '0;
            r_cnt      <= '0;
          end
        end
        S_HOLD: begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
          if (r_hold_cnt == HOLD_LAST) r_state <= S_RUN;
        end
        S_RUN: begin
          // The halting cycle is not counted; done also beats the timeout.
          if (core_done) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == CNT_MAX) r_state <= S_TIMEOUT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_run     = (r_state == S_RUN);
  assign w_host_ok = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_TIMEOUT);

  assign host_ack    = host_we & w_host_ok;
  assign mem_we      = w_run ? core_mem_we    : (host_we & w_host_ok);
  assign mem_addr    = w_run ? core_mem_addr  : host_addr;
  assign mem_wdata   = w_run ? core_mem_wdata : host_wdata;
  assign core_reset  = !w_run;
  assign busy        = (r_state == S_HOLD) || w_run;
  assign finished    = (r_state == S_DONE);
  assign timed_out   = (r_state == S_TIMEOUT);
  assign cycle_count = r_cnt;
endmodule
